// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared types and constants for the native-to-AXI-Lite bridge
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } bridge_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] PROT_DATA   = 3'b000;
  localparam logic [2:0] PROT_INSTR  = 3'b100;

endpackage

// File: rtl/axil_timeout_counter.sv
// rtl/axil_timeout_counter.sv - per-access wait counter; expired fires on the TIMEOUT_CYCLES-th enabled cycle
module axil_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic aclk,
  input  logic areset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero limit disables the watchdog entirely.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      assign expired = enable && (count_q == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/native_to_axil_master.sv
// rtl/native_to_axil_master.sv - CPU native memory port to single-outstanding AXI-Lite master with error reporting
module native_to_axil_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [STRB_WIDTH-1:0] mem_wstrb,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_error,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  bridge_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [2:0]            prot_q, prot_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic tmo_clear, tmo_expired;
  logic aw_all, w_all;
  logic unused_addr_bits;

  assign unused_addr_bits = ^mem_addr[1:0];

  assign aw_all    = aw_done_q || (m_axil_awvalid && m_axil_awready);
  assign w_all     = w_done_q || (m_axil_wvalid && m_axil_wready);
  assign tmo_clear = (state_q == IDLE) || (state_q == DONE);

  axil_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .aclk   (aclk),
    .areset (areset),
    .clear  (tmo_clear),
    .enable (!tmo_clear),
    .expired(tmo_expired)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshakes are tested before expiry so a same-cycle tie completes normally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_valid) state_d = (|mem_wstrb) ? WRITE : RADDR;
      WRITE:   if (aw_all && w_all) state_d = WRESP;
               else if (tmo_expired) state_d = DONE;
      WRESP:   if (m_axil_bvalid || tmo_expired) state_d = DONE;
      RADDR:   if (m_axil_arready) state_d = RDATA;
               else if (tmo_expired) state_d = DONE;
      RDATA:   if (m_axil_rvalid || tmo_expired) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    mem_ready      = 1'b0;
    case (state_q)
      WRITE: begin
        m_axil_awvalid = !aw_done_q;
        m_axil_wvalid  = !w_done_q;
      end
      WRESP:   m_axil_bready  = 1'b1;
      RADDR:   m_axil_arvalid = 1'b1;
      RDATA:   m_axil_rready  = 1'b1;
      DONE:    mem_ready      = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    prot_d    = prot_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d    = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          prot_d    = mem_instr ? PROT_INSTR : PROT_DATA;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WRITE: begin
        aw_done_d = aw_all;
        w_done_d  = w_all;
        if (!(aw_all && w_all) && tmo_expired) begin
          rdata_d = '0;
          error_d = 1'b1;
        end
      end
      WRESP: begin
        if (m_axil_bvalid) begin
          error_d = (m_axil_bresp != RESP_OKAY);
        end else if (tmo_expired) begin
          rdata_d = '0;
          error_d = 1'b1;
        end
      end
      RADDR: begin
        if (!m_axil_arready && tmo_expired) begin
          rdata_d = '0;
          error_d = 1'b1;
        end
      end
      RDATA: begin
        if (m_axil_rvalid) begin
          rdata_d = m_axil_rdata;
          error_d = (m_axil_rresp != RESP_OKAY);
        end else if (tmo_expired) begin
          rdata_d = '0;
          error_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      prot_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      prot_q    <= prot_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
    end
  end

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_awprot = prot_q;
  assign m_axil_arprot = prot_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign mem_rdata     = rdata_q;
  assign mem_error     = error_q;

endmodule
